// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the shared shift-add multiplier block.
//   DEFAULT_W : default operand width in bits
//   state_t   : control FSM states (IDLE, MUL, RESP)
// ---------------------------------------------------------------------------
package mult_pkg;

    localparam int DEFAULT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mult_seq_core.sv
// ---------------------------------------------------------------------------
// mult_seq_core
// Sequential shift-add multiplier datapath: operand registers, owner id,
// 2W-bit accumulator and iteration counter. Performs one iteration per cycle
// while step is high; sequencing is owned by the caller.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : load a_in/b_in/id_in, clear accumulator and counter
//   a_in, b_in   : W-bit unsigned operands
//   id_in        : owner id to carry alongside the operation
//   step         : perform one shift-add iteration this cycle
//   done         : high during the final iteration (counter == W-1 and step)
//   product      : accumulator (complete once the final iteration retires)
//   id           : captured owner id
// ---------------------------------------------------------------------------
module mult_seq_core
    import mult_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a_in,
    input  logic [W-1:0]   b_in,
    input  logic           id_in,
    input  logic           step,
    output logic           done,
    output logic [2*W-1:0] product,
    output logic           id
);

    localparam int CNT_W = (W > 2) ? $clog2(W) : 1;

    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [2*W-1:0]   acc;
    logic [CNT_W-1:0] cnt;
    logic             id_reg;
    logic [2*W-1:0]   partial;

    // Iteration k contributes (a << k) only when bit k of b is set; the
    // zero-extension keeps the full 2W-bit width so nothing is shifted out.
    always_comb begin
        partial = '0;
        if (b_reg[cnt]) begin
            partial = {{W{1'b0}}, a_reg} << cnt;
        end
    end

    assign done    = step && (cnt == CNT_W'(W - 1));
    assign product = acc;
    assign id      = id_reg;

    // Operand capture and the accumulate loop. The counter parks at W-1
    // after the final iteration so it never needs to wrap for non-power-of-2
    // widths; the next start clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg  <= '0;
            b_reg  <= '0;
            acc    <= '0;
            cnt    <= '0;
            id_reg <= 1'b0;
        end else if (start) begin
            a_reg  <= a_in;
            b_reg  <= b_in;
            id_reg <= id_in;
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            acc <= acc + partial;
            if (!done) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// ---------------------------------------------------------------------------
// mult_share_arbiter
// One sequential multiplier shared by two requesters with round-robin
// arbitration. A granted operation takes W MUL cycles, then the result is
// held in RESP until the consumer accepts it.
//
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   reqN_valid, reqN_a, reqN_b    : requester N operands pending (N = 0, 1)
//   reqN_ready                    : requester N accepted this cycle (IDLE only)
//   rsp_valid, rsp_id, rsp_product: result presented, owner, unsigned product
//   rsp_ready                     : consumer accepts the result
//   busy                          : high whenever not IDLE
// ---------------------------------------------------------------------------
module mult_share_arbiter
    import mult_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    output logic           req1_ready,
    output logic           rsp_valid,
    output logic           rsp_id,
    output logic [2*W-1:0] rsp_product,
    input  logic           rsp_ready,
    output logic           busy
);

    state_t           state;
    state_t           state_next;
    logic             last_grant;
    logic             grant0;
    logic             grant1;
    logic             core_start;
    logic             core_step;
    logic             core_done;
    logic [2*W-1:0]   core_product;
    logic             core_id;
    logic [W-1:0]     sel_a;
    logic [W-1:0]     sel_b;

    // Round-robin: a lone requester always wins; with both pending, the one
    // that was not served last wins. The two grants are mutually exclusive.
    assign grant0 = req0_valid && (!req1_valid || last_grant);
    assign grant1 = req1_valid && (!req0_valid || !last_grant);
    assign sel_a  = grant1 ? req1_a : req0_a;
    assign sel_b  = grant1 ? req1_b : req0_b;

    mult_seq_core #(.W(W)) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (core_start),
        .a_in    (sel_a),
        .b_in    (sel_b),
        .id_in   (grant1),
        .step    (core_step),
        .done    (core_done),
        .product (core_product),
        .id      (core_id)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, leave MUL on the last iteration,
    // leave RESP on the response handshake.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req0_valid || req1_valid) state_next = MUL;
            MUL:  if (core_done)                state_next = RESP;
            RESP: if (rsp_ready)                state_next = IDLE;
            default:                            state_next = IDLE;
        endcase
    end

    // Output decode. Readies are additionally gated by rst_n so nothing is
    // advertised while reset is held, even though the state reads IDLE.
    always_comb begin
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        core_start  = 1'b0;
        core_step   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_id      = 1'b0;
        rsp_product = '0;
        busy        = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = rst_n && grant0;
                req1_ready = rst_n && grant1;
                core_start = grant0 || grant1;
            end
            MUL: begin
                busy      = 1'b1;
                core_step = 1'b1;
            end
            RESP: begin
                busy        = 1'b1;
                rsp_valid   = 1'b1;
                rsp_id      = core_id;
                rsp_product = core_product;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Last-granted pointer moves only when a result is handed off, so an
    // operation killed by reset never counts as a turn. Reset value 1 lets
    // requester 0 win the first contested arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (state == RESP && rsp_ready) begin
            last_grant <= core_id;
        end
    end

endmodule

// File: doc/mult_share_arbiter.md
MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 SHALL have parameter W, default 4, giving the operand width in bits (W >= 2).
REQ-002 SHALL have input clk, 1 bit, the single rising-edge clock.
REQ-003 SHALL have input rst_n, 1 bit, an asynchronous active-low reset.
REQ-004 SHALL have input req0_valid, 1 bit, meaning requester 0 has operands pending.
REQ-005 SHALL have inputs req0_a and req0_b, W bits each, the requester 0 operands.
REQ-006 SHALL have output req0_ready, 1 bit; requester 0 operands are accepted in a cycle where req0_valid and req0_ready are both high.
REQ-007 SHALL have req1_valid, req1_a, req1_b and req1_ready, identical to REQ-004..006 but for requester 1.
REQ-008 SHALL have output rsp_valid, 1 bit, meaning a result is presented.
REQ-009 SHALL have output rsp_id, 1 bit, giving the index of the requester that owns the result.
REQ-010 SHALL have output rsp_product, 2W bits, the unsigned product.
REQ-011 SHALL have input rsp_ready, 1 bit; the result is consumed in a cycle where rsp_valid and rsp_ready are both high.
REQ-012 SHALL have output busy, 1 bit, high whenever the state is not IDLE.

Function
REQ-013 SHALL implement an FSM with states IDLE, MUL and RESP.
REQ-014 IDLE: if either valid is high, SHALL grant exactly one requester, capture its a, b and id, clear the accumulator and counter, and go to MUL next cycle.
REQ-015 Arbitration SHALL be round-robin: with both valids high, the requester not granted last wins; with one valid high, that requester wins.
REQ-016 req0_ready and req1_ready SHALL be combinational: high only in IDLE, and only for the requester that wins arbitration that cycle; never both high.
REQ-017 MUL SHALL run a shift-add multiply for exactly W cycles. On iteration k (0..W-1), if b[k]=1, it adds (a zero-extended to 2W) << k to the accumulator.
REQ-018 After iteration W-1, SHALL enter RESP with rsp_valid=1, rsp_product=a*b, and rsp_id=captured id.
REQ-019 Latency SHALL be fixed: operands accepted at cycle T give rsp_valid high at T+W+1, independent of operand values (including zero).
REQ-020 RESP: rsp_valid, rsp_id and rsp_product SHALL stay stable until rsp_ready is high.
REQ-021 On the rsp_valid & rsp_ready cycle, the block SHALL go to IDLE next cycle and update the last-granted pointer to rsp_id.
REQ-022 The next accept SHALL occur no earlier than the first IDLE cycle; throughput is one operation per W+2 cycles at best.
REQ-023 rsp_ready already high when RESP is entered SHALL complete the handshake in that first RESP cycle.
REQ-024 Requester valids and operands SHALL be ignored outside IDLE; the held operands do not change during MUL or RESP.
REQ-025 Arithmetic SHALL be unsigned; a 2W-bit accumulator cannot overflow, and (2^W-1)^2 SHALL be exact.

Reset
REQ-026 rst_n low SHALL asynchronously force state IDLE, accumulator 0, counter 0, captured operands 0, id 0, and last-granted pointer 1, so requester 0 wins first.
REQ-027 Under reset, outputs SHALL be rsp_valid=0, rsp_id=0, rsp_product=0, busy=0, and both readies 0.
REQ-028 Reset asserted in MUL or RESP SHALL discard the operation; no response is produced for it.

Structure
REQ-029 A shared package mult_pkg SHALL hold the FSM state typedef and the default operand width constant.
REQ-030 The shift-add datapath (accumulator, counter, operand registers) SHALL be the sub-module mult_seq_core with start/done ports; arbitration and the FSM stay in the top level.

Verification
REQ-031 Test 1: req0 alone, a=3, b=5 -> req0_ready high one cycle; rsp_valid at T+5, rsp_id=0, rsp_product=15.
REQ-032 Test 2: req1 alone, a=15, b=15 -> rsp_id=1, rsp_product=225 at T+5.
REQ-033 Test 3: both valid right after reset, with (2,7) on req0 and (4,4) on req1 -> req0 served first with 14, then req1 with 16; then with both still valid, req0 is granted next.
REQ-034 Test 4: a=9, b=6, rsp_ready held low 6 cycles -> rsp_valid, rsp_id and rsp_product=54 held stable; IDLE the cycle after rsp_ready rises.
REQ-035 Test 5: a=0, b=9 -> product 0 with latency still W+1; then a=9, b=0 -> product 0.
REQ-036 Test 6: rst_n pulsed low during MUL iteration 2 -> busy=0 immediately, no rsp_valid; the next req1 request completes correctly.
